// File: rtl/flash_bus_pkg.sv
// Shared types and constants for the 6809-to-SPI-flash read bridge.
// The decode defaults are also used by the top-level address decoder.
package flash_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REQ,
    ST_BUSY,
    ST_DONE
  } state_e;

  localparam int          TMO_W          = 10;
  localparam logic [7:0]  ERR_FILL       = 8'hFF;
  localparam logic [15:0] FLASH_BASE_DEF = 16'hC000;
  localparam logic [15:0] FLASH_MASK_DEF = 16'hC000;

  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] mask,
                                     input logic [15:0] base);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/flash_read_cache.sv
// Single-entry read cache: one tag/data/valid register.
// An invalidate landing while a fill is in flight marks that fill as stale (kill).
module flash_read_cache
  import flash_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] lookup_addr,
  output logic        hit,
  output logic [7:0]  rdata,
  input  logic        fill,
  input  logic [7:0]  fill_data,
  input  logic        invalidate,
  input  logic        kill_clr
);

  logic        valid_q;
  logic        kill_q;
  logic [15:0] tag_q;
  logic [7:0]  data_q;

  // Lookup sees the registered valid, so an invalidate in the lookup cycle
  // only takes effect on the next read.
  assign hit   = valid_q && (tag_q == lookup_addr);
  assign rdata = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (invalidate)    kill_q <= 1'b1;
      else if (kill_clr) kill_q <= 1'b0;

      if (fill) begin
        tag_q   <= lookup_addr;
        data_q  <= fill_data;
        valid_q <= !(kill_q || invalidate);
      end else if (invalidate) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/flash_read_bridge.sv
// Decodes 6809 reads into the flash window, stretches the CPU with MRDY while
// the SPI controller fetches the byte, and serves repeat reads from a 1-entry cache.
module flash_read_bridge
  import flash_bus_pkg::*;
#(
  parameter logic [15:0] FLASH_BASE     = FLASH_BASE_DEF,
  parameter logic [15:0] FLASH_MASK     = FLASH_MASK_DEF,
  parameter logic [23:0] ADDR_OFFSET    = 24'h000000,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        i_RESET_N,
  input  logic [15:0] i_ADDRESS_BUS,
  input  logic        i_RW,
  input  logic        i_BUS_VALID,
  input  logic        i_INVALIDATE,
  input  logic        i_ERR_CLR,
  output logic        o_FLASH_REQ,
  output logic [23:0] o_FLASH_ADDR,
  input  logic        i_FLASH_READY,
  input  logic [7:0]  i_FLASH_DATA,
  output logic [7:0]  o_DATA,
  output logic        o_DATA_OE,
  output logic        o_MRDY,
  output logic        o_BUS_ERR
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              gone_q, gone_d, gone_nx;
  logic              req_d, oe_d, mrdy_d, err_d, err_set;
  logic [23:0]       faddr_d;
  logic [7:0]        data_d;
  logic              hit_window, cache_hit, fill, kill_clr, xfer_end;
  logic [7:0]        cache_data;

  assign hit_window = i_BUS_VALID && in_window(i_ADDRESS_BUS, FLASH_MASK, FLASH_BASE);

  flash_read_cache u_cache (
    .clk         (clk),
    .rst_n       (i_RESET_N),
    .lookup_addr (addr_q),
    .hit         (cache_hit),
    .rdata       (cache_data),
    .fill        (fill),
    .fill_data   (i_FLASH_DATA),
    .invalidate  (i_INVALIDATE),
    .kill_clr    (kill_clr)
  );

  always_ff @(posedge clk or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      gone_q       <= 1'b0;
      o_FLASH_REQ  <= 1'b0;
      o_FLASH_ADDR <= '0;
      o_DATA       <= 8'h00;
      o_DATA_OE    <= 1'b0;
      o_MRDY       <= 1'b1;
      o_BUS_ERR    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      gone_q       <= gone_d;
      o_FLASH_REQ  <= req_d;
      o_FLASH_ADDR <= faddr_d;
      o_DATA       <= data_d;
      o_DATA_OE    <= oe_d;
      o_MRDY       <= mrdy_d;
      o_BUS_ERR    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    gone_d   = gone_q;
    gone_nx  = gone_q;
    req_d    = o_FLASH_REQ;
    faddr_d  = o_FLASH_ADDR;
    data_d   = o_DATA;
    oe_d     = o_DATA_OE;
    mrdy_d   = o_MRDY;
    err_set  = 1'b0;
    fill     = 1'b0;
    kill_clr = 1'b0;
    xfer_end = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (hit_window) begin
          if (i_RW) begin
            addr_d  = i_ADDRESS_BUS;
            state_d = ST_LOOKUP;
          end else begin
            // Writes into ROM space: flag and park in DONE until the cycle ends.
            err_set = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_LOOKUP: begin
        if (cache_hit) begin
          data_d  = cache_data;
          oe_d    = i_BUS_VALID;
          state_d = ST_DONE;
        end else begin
          mrdy_d   = 1'b0;
          req_d    = 1'b1;
          faddr_d  = ADDR_OFFSET + {8'h00, addr_q};
          cnt_d    = '0;
          gone_d   = !i_BUS_VALID;
          kill_clr = 1'b1;
          state_d  = ST_REQ;
        end
      end

      ST_REQ, ST_BUSY: begin
        // A CPU that walks away mid-fetch still gets its byte cached, just not driven.
        gone_nx = gone_q || !i_BUS_VALID;
        gone_d  = gone_nx;
        if (state_q == ST_BUSY && i_FLASH_READY) begin
          fill     = 1'b1;
          data_d   = i_FLASH_DATA;
          xfer_end = 1'b1;
        end else if (cnt_q == TMO_LIM) begin
          data_d   = ERR_FILL;
          err_set  = 1'b1;
          xfer_end = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == ST_REQ && !i_FLASH_READY) state_d = ST_BUSY;
        end
      end

      ST_DONE: begin
        if (!i_BUS_VALID) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (xfer_end) begin
      req_d   = 1'b0;
      mrdy_d  = 1'b1;
      oe_d    = !gone_nx;
      state_d = gone_nx ? ST_IDLE : ST_DONE;
    end

    err_d = err_set ? 1'b1 : (i_ERR_CLR ? 1'b0 : o_BUS_ERR);
  end

endmodule
